// File: rtl/bus_transfer_controller_if.sv
// Bundle of control-unit handshake and register-bus signals for the transfer controller.
// The controller takes the master view; the control unit / register file take the slave view.
interface bus_transfer_controller_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 4,
    parameter int SEL_WIDTH  = 2
);
    logic                  xfer_start;
    logic [SEL_WIDTH-1:0]  xfer_src;
    logic [SEL_WIDTH-1:0]  xfer_dst;
    logic                  xfer_busy;
    logic                  xfer_done;
    logic                  xfer_error;
    logic [NUM_REGS-1:0]   reg_read_sel;
    logic [DATA_WIDTH-1:0] bus_register_output;
    logic                  bus_register_out_en;
    logic [DATA_WIDTH-1:0] bus_register_input;
    logic [NUM_REGS-1:0]   bus_register_input_en;

    modport master (
        input  xfer_start, xfer_src, xfer_dst, bus_register_output, bus_register_out_en,
        output xfer_busy, xfer_done, xfer_error, reg_read_sel, bus_register_input,
               bus_register_input_en
    );

    modport slave (
        output xfer_start, xfer_src, xfer_dst, bus_register_output, bus_register_out_en,
        input  xfer_busy, xfer_done, xfer_error, reg_read_sel, bus_register_input,
               bus_register_input_en
    );
endinterface

// File: rtl/bus_transfer_controller.sv
// Register-bus master: reads one word from a source register and writes it to a destination,
// with a bounded wait on the source's output-valid.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for xfer_start; busy low
// S_REQ   | read select asserted, waiting up to TIMEOUT cycles for out_en
// S_WRITE | captured word driven with a one-cycle one-hot write enable
// S_DONE  | one-cycle done pulse, error reports a timeout
module bus_transfer_controller #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int TIMEOUT    = 8
) (
    input logic                     register_clock,
    input logic                     register_reset,
    bus_transfer_controller_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0]          CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [NUM_REGS-1:0] ONE_HOT0 = NUM_REGS'(1);

    state_t                state_q, state_d;
    logic [SEL_WIDTH-1:0]  src_q, src_d;
    logic [SEL_WIDTH-1:0]  dst_q, dst_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [NUM_REGS-1:0]   read_sel_q, read_sel_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0]   wr_en_q, wr_en_d;

    always_ff @(posedge register_clock or negedge register_reset) begin
        if (!register_reset) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            read_sel_q <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            read_sel_q <= read_sel_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        read_sel_d = '0;
        wr_data_d  = '0;
        wr_en_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.xfer_start) begin
                    src_d   = bus.xfer_src;
                    dst_d   = bus.xfer_dst;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A response on the last allowed cycle still counts as success.
                if (bus.bus_register_out_en) begin
                    data_d  = bus.bus_register_output;
                    state_d = S_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so every port comes straight from a flop.
        case (state_d)
            S_REQ: begin
                busy_d     = 1'b1;
                read_sel_d = ONE_HOT0 << src_d;
            end
            S_WRITE: begin
                busy_d    = 1'b1;
                wr_data_d = data_d;
                wr_en_d   = ONE_HOT0 << dst_d;
            end
            S_DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                error_d = err_d;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.xfer_busy             = busy_q;
    assign bus.xfer_done             = done_q;
    assign bus.xfer_error            = error_q;
    assign bus.reg_read_sel          = read_sel_q;
    assign bus.bus_register_input    = wr_data_q;
    assign bus.bus_register_input_en = wr_en_q;

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Directed self-checking bench for bus_transfer_controller (TIMEOUT = 8, four registers).
module tb_bus_transfer_controller;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    bus_transfer_controller_if #(.DATA_WIDTH(16), .NUM_REGS(4), .SEL_WIDTH(2)) bus ();

    bus_transfer_controller #(
        .DATA_WIDTH(16), .NUM_REGS(4), .SEL_WIDTH(2), .TIMEOUT(8)
    ) dut (
        .register_clock(clk),
        .register_reset(rst_n),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one transfer and plays the register file: answers with rdata on REQ cycle resp_at
    // (0 = never), optionally pulses xfer_start with src=3 on REQ cycle poke_at, and records
    // what the controller did until three cycles after its done pulse.
    task automatic run_xfer(
        input  logic [1:0]  src,
        input  logic [1:0]  dst,
        input  int          resp_at,
        input  logic [15:0] rdata,
        input  int          poke_at,
        output int          req_n,
        output int          sel_bad,
        output int          wr_n,
        output int          wr_at,
        output logic [3:0]  wr_en,
        output logic [15:0] wr_data,
        output int          done_n,
        output int          done_at,
        output logic        err,
        output int          busy_n,
        output bit          timed_out
    );
        int         since_done;
        logic [3:0] exp_sel;
        exp_sel = 4'b0001 << src;
        req_n = 0; sel_bad = 0; wr_n = 0; wr_at = -1; wr_en = '0; wr_data = '0;
        done_n = 0; done_at = -1; err = 1'b0; busy_n = 0; timed_out = 1'b1;
        since_done = -1;
        @(negedge clk);
        bus.xfer_start = 1'b1;
        bus.xfer_src   = src;
        bus.xfer_dst   = dst;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.xfer_start          = 1'b0;
            bus.bus_register_out_en = 1'b0;
            bus.bus_register_output = '0;
            if (bus.xfer_busy) busy_n++;
            if (bus.reg_read_sel != 4'b0000) begin
                req_n++;
                if (bus.reg_read_sel !== exp_sel) sel_bad++;
                if (req_n == resp_at) begin
                    bus.bus_register_out_en = 1'b1;
                    bus.bus_register_output = rdata;
                end
                if (req_n == poke_at) begin
                    bus.xfer_start = 1'b1;
                    bus.xfer_src   = 2'd3;
                    bus.xfer_dst   = 2'd3;
                end
            end
            if (bus.bus_register_input_en != 4'b0000) begin
                wr_n++;
                wr_at   = c;
                wr_en   = bus.bus_register_input_en;
                wr_data = bus.bus_register_input;
            end
            if (since_done >= 0) since_done++;
            if (bus.xfer_done) begin
                done_n++;
                err = bus.xfer_error;
                if (since_done < 0) begin
                    since_done = 0;
                    done_at    = c;
                end
            end
            if (since_done == 3) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({bus.xfer_busy, bus.xfer_done, bus.xfer_error, bus.reg_read_sel,
             bus.bus_register_input, bus.bus_register_input_en} !== 27'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b sel=%b in=%h en=%b want all 0",
                     bus.xfer_busy, bus.xfer_done, bus.xfer_error, bus.reg_read_sel,
                     bus.bus_register_input, bus.bus_register_input_en);
        end
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.xfer_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle_busy: got %b want 0", bus.xfer_busy);
        end
    endtask

    task automatic test_normal();
        int req_n, sel_bad, wr_n, wr_at, done_n, done_at, busy_n;
        logic [3:0] wr_en; logic [15:0] wr_data; logic err; bit to;
        run_xfer(2'd1, 2'd2, 1, 16'hA5A5, 0, req_n, sel_bad, wr_n, wr_at, wr_en, wr_data,
                 done_n, done_at, err, busy_n, to);
        compared++; if (to) begin mismatched++; $display("FAIL normal_wait: no done within bound"); end
        compared++; if (req_n !== 1 || sel_bad !== 0) begin mismatched++; $display("FAIL normal_read_sel: got cycles=%0d bad=%0d want 1/0", req_n, sel_bad); end
        compared++; if (wr_n !== 1 || wr_at !== 1) begin mismatched++; $display("FAIL normal_write_timing: got n=%0d at=%0d want 1/1", wr_n, wr_at); end
        compared++; if (wr_en !== 4'b0100 || wr_data !== 16'hA5A5) begin mismatched++; $display("FAIL normal_write: got en=%b data=%h want 0100/a5a5", wr_en, wr_data); end
        compared++; if (done_n !== 1 || done_at !== 2 || err !== 1'b0) begin mismatched++; $display("FAIL normal_done: got n=%0d at=%0d err=%b want 1/2/0", done_n, done_at, err); end
        compared++; if (busy_n !== 3) begin mismatched++; $display("FAIL normal_busy: got %0d want 3", busy_n); end
    endtask

    task automatic test_delayed();
        int req_n, sel_bad, wr_n, wr_at, done_n, done_at, busy_n;
        logic [3:0] wr_en; logic [15:0] wr_data; logic err; bit to;
        run_xfer(2'd0, 2'd3, 4, 16'h1234, 0, req_n, sel_bad, wr_n, wr_at, wr_en, wr_data,
                 done_n, done_at, err, busy_n, to);
        compared++; if (to) begin mismatched++; $display("FAIL delayed_wait: no done within bound"); end
        compared++; if (req_n !== 4 || sel_bad !== 0) begin mismatched++; $display("FAIL delayed_req: got cycles=%0d bad=%0d want 4/0", req_n, sel_bad); end
        compared++; if (wr_n !== 1 || wr_at !== 4 || wr_en !== 4'b1000 || wr_data !== 16'h1234) begin mismatched++; $display("FAIL delayed_write: got n=%0d at=%0d en=%b data=%h want 1/4/1000/1234", wr_n, wr_at, wr_en, wr_data); end
        compared++; if (done_n !== 1 || done_at !== 5 || err !== 1'b0 || busy_n !== 6) begin mismatched++; $display("FAIL delayed_done: got n=%0d at=%0d err=%b busy=%0d want 1/5/0/6", done_n, done_at, err, busy_n); end
    endtask

    task automatic test_timeout();
        int req_n, sel_bad, wr_n, wr_at, done_n, done_at, busy_n;
        logic [3:0] wr_en; logic [15:0] wr_data; logic err; bit to;
        run_xfer(2'd2, 2'd0, 0, 16'h0000, 0, req_n, sel_bad, wr_n, wr_at, wr_en, wr_data,
                 done_n, done_at, err, busy_n, to);
        compared++; if (to) begin mismatched++; $display("FAIL timeout_wait: no done within bound"); end
        compared++; if (req_n !== 8 || sel_bad !== 0) begin mismatched++; $display("FAIL timeout_req: got cycles=%0d bad=%0d want 8/0", req_n, sel_bad); end
        compared++; if (wr_n !== 0) begin mismatched++; $display("FAIL timeout_no_write: got %0d writes want 0", wr_n); end
        compared++; if (done_n !== 1 || done_at !== 8 || err !== 1'b1 || busy_n !== 9) begin mismatched++; $display("FAIL timeout_done: got n=%0d at=%0d err=%b busy=%0d want 1/8/1/9", done_n, done_at, err, busy_n); end
    endtask

    task automatic test_boundary_busy();
        int req_n, sel_bad, wr_n, wr_at, done_n, done_at, busy_n;
        logic [3:0] wr_en; logic [15:0] wr_data; logic err; bit to;
        run_xfer(2'd1, 2'd0, 8, 16'h00FF, 3, req_n, sel_bad, wr_n, wr_at, wr_en, wr_data,
                 done_n, done_at, err, busy_n, to);
        compared++; if (to) begin mismatched++; $display("FAIL boundary_wait: no done within bound"); end
        compared++; if (req_n !== 8 || sel_bad !== 0) begin mismatched++; $display("FAIL boundary_req_src_kept: got cycles=%0d bad=%0d want 8/0", req_n, sel_bad); end
        compared++; if (wr_n !== 1 || wr_at !== 8 || wr_en !== 4'b0001 || wr_data !== 16'h00FF) begin mismatched++; $display("FAIL boundary_write: got n=%0d at=%0d en=%b data=%h want 1/8/0001/00ff", wr_n, wr_at, wr_en, wr_data); end
        compared++; if (done_n !== 1 || err !== 1'b0 || busy_n !== 10) begin mismatched++; $display("FAIL boundary_done: got n=%0d err=%b busy=%0d want 1/0/10", done_n, err, busy_n); end
    endtask

    task automatic test_idle_out_en();
        int busy_n, wr_n;
        busy_n = 0; wr_n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.bus_register_out_en = (c < 2);
            bus.bus_register_output = 16'hDEAD;
            if (bus.xfer_busy) busy_n++;
            if (bus.bus_register_input_en != 4'b0000) wr_n++;
        end
        bus.bus_register_out_en = 1'b0;
        compared++;
        if (busy_n !== 0 || wr_n !== 0) begin
            mismatched++;
            $display("FAIL idle_out_en_ignored: got busy=%0d writes=%0d want 0/0", busy_n, wr_n);
        end
    endtask

    task automatic test_mid_reset();
        int req_n, sel_bad, wr_n, wr_at, done_n, done_at, busy_n;
        logic [3:0] wr_en; logic [15:0] wr_data; logic err; bit to;
        int late_wr, late_done, late_busy;
        @(negedge clk);
        bus.xfer_start = 1'b1; bus.xfer_src = 2'd2; bus.xfer_dst = 2'd1;
        @(negedge clk);
        bus.xfer_start = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.reg_read_sel !== 4'b0100) begin mismatched++; $display("FAIL midreset_in_req: got sel=%b want 0100", bus.reg_read_sel); end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({bus.xfer_busy, bus.xfer_done, bus.xfer_error, bus.reg_read_sel,
             bus.bus_register_input, bus.bus_register_input_en} !== 27'd0) begin
            mismatched++;
            $display("FAIL midreset_outputs: got busy=%b sel=%b en=%b want all 0",
                     bus.xfer_busy, bus.reg_read_sel, bus.bus_register_input_en);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        late_wr = 0; late_done = 0; late_busy = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.bus_register_out_en = (c == 0);
            bus.bus_register_output = 16'h7777;
            if (bus.bus_register_input_en != 4'b0000) late_wr++;
            if (bus.xfer_done) late_done++;
            if (bus.xfer_busy) late_busy++;
        end
        bus.bus_register_out_en = 1'b0;
        compared++;
        if (late_wr !== 0 || late_done !== 0 || late_busy !== 0) begin
            mismatched++;
            $display("FAIL midreset_aborted: got writes=%0d dones=%0d busy=%0d want 0/0/0", late_wr, late_done, late_busy);
        end
        run_xfer(2'd2, 2'd1, 1, 16'h5A5A, 0, req_n, sel_bad, wr_n, wr_at, wr_en, wr_data,
                 done_n, done_at, err, busy_n, to);
        compared++;
        if (to || wr_n !== 1 || wr_en !== 4'b0010 || wr_data !== 16'h5A5A || done_n !== 1 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_recover: got to=%b n=%0d en=%b data=%h done=%0d err=%b want 0/1/0010/5a5a/1/0",
                     to, wr_n, wr_en, wr_data, done_n, err);
        end
    endtask

    task automatic test_same_reg();
        int req_n, sel_bad, wr_n, wr_at, done_n, done_at, busy_n;
        logic [3:0] wr_en; logic [15:0] wr_data; logic err; bit to;
        run_xfer(2'd1, 2'd1, 1, 16'hBEEF, 0, req_n, sel_bad, wr_n, wr_at, wr_en, wr_data,
                 done_n, done_at, err, busy_n, to);
        compared++; if (to || req_n !== 1 || sel_bad !== 0) begin mismatched++; $display("FAIL same_read: got to=%b cycles=%0d bad=%0d want 0/1/0", to, req_n, sel_bad); end
        compared++; if (wr_n !== 1 || wr_en !== 4'b0010 || wr_data !== 16'hBEEF) begin mismatched++; $display("FAIL same_write: got n=%0d en=%b data=%h want 1/0010/beef", wr_n, wr_en, wr_data); end
        compared++; if (done_n !== 1 || err !== 1'b0) begin mismatched++; $display("FAIL same_done: got n=%0d err=%b want 1/0", done_n, err); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        bus.xfer_start          = 1'b0;
        bus.xfer_src            = '0;
        bus.xfer_dst            = '0;
        bus.bus_register_output = '0;
        bus.bus_register_out_en = 1'b0;
        test_reset();
        test_normal();
        test_delayed();
        test_timeout();
        test_boundary_busy();
        test_idle_out_en();
        test_mid_reset();
        test_same_reg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bus_transfer_controller.md
Name: bus_transfer_controller

Overview:
- Bus-side master for the 16-bit register bus.
- Moves one word from a source register to a destination register in a single transfer:
  - requests a read from the source;
  - waits for that register's output-valid (bus_register_out_en) and captures bus_register_output;
  - drives the word back onto bus_register_input with a one-cycle bus_register_input_en to the destination.
- Sits between the control unit (start/select/done) and the register file.
- Includes a bounded wait so that a register that never responds cannot hang the bus.

Parameters:
- DATA_WIDTH, 16: bus word width.
- NUM_REGS, 4: registers on the bus. Must be a power of two, ≥2.
- SEL_WIDTH, 2: log2(NUM_REGS), width of the register index.
- TIMEOUT, 8: maximum number of REQ cycles to wait for bus_register_out_en. Must be ≥1 and ≤255.

Ports:
- register_clock  in  1  system clock, rising edge.
- register_reset  in  1  asynchronous, active-low reset (0 = reset).
- xfer_start  in  1  one-cycle request to start a transfer; sampled only in IDLE.
- xfer_src  in  SEL_WIDTH  source register index, latched on accepted start.
- xfer_dst  in  SEL_WIDTH  destination register index, latched on accepted start.
- xfer_busy  out  1  high in every state except IDLE.
- xfer_done  out  1  one-cycle pulse when a transfer ends, whether it succeeded or timed out.
- xfer_error  out  1  valid with xfer_done; 1 = timed out, no write was performed.
- reg_read_sel  out  NUM_REGS  one-hot read request to the source register.
- bus_register_output  in  DATA_WIDTH  registered word from the register file (muxed bus).
- bus_register_out_en  in  1  the selected register's output is valid this cycle.
- bus_register_input  out  DATA_WIDTH  write data to the registers.
- bus_register_input_en  out  NUM_REGS  one-hot write enable.

Behaviour:
- Reset (register_reset=0, asynchronous):
  - state goes to IDLE;
  - all outputs are 0;
  - latched src, dst, data and wait counter are cleared.
- Release of reset is synchronous to register_clock.
- All outputs are registered.
- States: IDLE, REQ, WRITE, DONE.
- IDLE:
  - xfer_busy=0.
  - On xfer_start=1, latch xfer_src, xfer_dst and clear the wait counter, then go to REQ.
- REQ:
  - reg_read_sel = one-hot(src); xfer_busy=1.
  - If bus_register_out_en=1: capture bus_register_output into data_q and go to WRITE.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 and out_en is still 0, set the error flag and go to DONE, skipping WRITE.
  - If out_en arrives on the same cycle the counter reaches TIMEOUT-1, out_en wins: the transfer succeeds.
- WRITE:
  - reg_read_sel=0.
  - bus_register_input = data_q.
  - bus_register_input_en = one-hot(dst) for exactly one cycle, then go to DONE.
- DONE:
  - xfer_done=1 and xfer_error=flag for one cycle, then go to IDLE.
  - The error flag is cleared when the next transfer is accepted.
- bus_register_input is 0 and bus_register_input_en is 0 outside WRITE.
- reg_read_sel is 0 outside REQ.
- Latency: with start sampled at edge k and out_en high in the first REQ cycle:
  - REQ is active during k+1;
  - WRITE during k+2;
  - xfer_done during k+3;
  - IDLE again at k+4, which is the earliest next start.
- Timeout case: REQ lasts exactly TIMEOUT cycles; DONE follows immediately with xfer_error=1.
- xfer_start while busy is ignored and not queued.
- xfer_src/xfer_dst changes after acceptance have no effect.
- src==dst is legal: the word is read back and rewritten unchanged.
- bus_register_out_en outside REQ is ignored.
- Reset asserted mid-transfer aborts immediately:
  - no write enable is issued;
  - no xfer_done pulse is produced.

Test Plan:
- Reset then normal transfer:
  - Stimulus: hold register_reset=0 for 3 cycles, then release. Start with src=1, dst=2. Source returns out_en=1 with 16'hA5A5 in the first REQ cycle.
  - Required: reg_read_sel=4'b0010 for 1 cycle; next cycle bus_register_input=16'hA5A5 with bus_register_input_en=4'b0100 for 1 cycle; xfer_done=1 and xfer_error=0 the cycle after; busy for exactly 3 cycles.
- Delayed response:
  - Stimulus: src=0, dst=3; out_en=1 with 16'h1234 on the 4th REQ cycle (TIMEOUT=8).
  - Required: REQ lasts 4 cycles; write of 16'h1234 with en=4'b1000; xfer_error=0.
- Timeout:
  - Stimulus: src=2; out_en is never asserted.
  - Required: reg_read_sel=4'b0100 for exactly 8 cycles; bus_register_input_en stays 0 throughout; xfer_done=1 with xfer_error=1.
- Boundary and busy:
  - Stimulus: out_en arrives on the 8th REQ cycle with 16'h00FF. Separately, pulse xfer_start with src=3 while in REQ.
  - Required: the 8th-cycle response succeeds and writes 16'h00FF. The start issued during REQ is ignored: the latched src is unchanged and exactly one xfer_done pulse is produced.
- Mid-transfer reset:
  - Stimulus: assert register_reset=0 asynchronously during REQ, between clock edges.
  - Required: all outputs are 0 immediately; no write enable and no xfer_done follow after release; a new start then completes normally.
- src==dst:
  - Stimulus: src=dst=1, data 16'hBEEF.
  - Required: reg_read_sel=4'b0010, then bus_register_input_en=4'b0010 with 16'hBEEF; xfer_error=0.
